load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage that sits directly downstream of the ALU: it takes the ALU result as the effective address.
//  It issues one data-memory read or write per accepted op over a req/gnt/rvalid handshake.
//  Loads are aligned, sign- or zero-extended and returned as a writeback result; stores return an ack.
//  It is multi-cycle and blocking. in_ready stalls the EX stage while a transaction is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles spent in REQ+WAIT before the op is aborted with a timeout fault
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   reset; synchronous, active-low
//  in_valid        in   1   EX stage presents an op
//  in_ready        out  1   1 only in IDLE while rst=1; accept = in_valid & in_ready
//  mem_op          in   4   [3]=store, [2]=unsigned (loads only), [1:0]=size: 00 B, 01 H, 10 W, 11 illegal
//  addr            in   32  effective address (ALU result)
//  store_data      in   32  store source; low bits are used per size
//  rd_in           in   5   destination register; carried to out_rd
//  dmem_req        out  1   memory request; held with stable addr/we/wdata/wstrb until dmem_gnt
//  dmem_we         out  1   1 = write
//  dmem_addr       out  32  {addr[31:2],2'b00}
//  dmem_wdata      out  32  lane-replicated store data
//  dmem_wstrb      out  4   byte enables; 0000 for loads
//  dmem_gnt        in   1   memory accepts request this cycle
//  dmem_rvalid     in   1   read data valid; considered only in WAIT
//  dmem_rdata      in   32  read word
//  out_valid       out  1   one-cycle completion pulse
//  out_data        out  32  load result; 0 for stores and faults
//  out_rd          out  5   captured rd_in
//  out_we          out  1   1 only for a successful load
//  out_fault       out  1   op aborted; valid with out_valid
//  out_cause       out  2   01 misaligned, 10 timeout, 11 illegal size, 00 none
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, all outputs 0. in_ready=0 while rst=0 and 1 on the first cycle after release.
//  Reset mid-op abandons the transaction; dmem_req is 0 after the reset edge; a late rvalid is ignored.
//  Operands are captured on accept.
//  Illegal size: size=11 -> cause 11.
//  Misaligned: H with addr[0]=1, or W with addr[1:0]!=0 -> cause 01.
//  Either case goes straight to DONE with no memory request.
//  FSM IDLE->REQ (legal accept) | DONE (fault accept).
//  REQ: dmem_req=1. On gnt, a store goes to DONE and a load goes to WAIT.
//  WAIT: on rvalid, extract the data and go to DONE.
//  DONE: out_valid=1 for one cycle, then IDLE; a new accept is possible in the following IDLE cycle.
//  Timeout counter: cleared on accept; increments each cycle in REQ or WAIT.
//  At TIMEOUT_CYCLES it drops dmem_req and goes to DONE with cause 10.
//  gnt and timeout in the same cycle: gnt wins. rvalid and timeout in the same cycle: rvalid wins.
//  Counter width is $clog2(TIMEOUT_CYCLES+1).
//  Latency from accept edge to out_valid: 1 cycle for a fault.
//  With the single-cycle gnt and rvalid of TESTING 2: store 2 cycles, load 3 cycles.
//  Each extra gnt or rvalid wait cycle adds 1.
//  Loads: lane = dmem_rdata >> (8*addr[1:0]).
//   B: lane[7:0]; H: lane[15:0]. Sign-extend, or zero-extend if unsigned. W: the full word.
//  Stores by size:
//   B: wdata {4{d[7:0]}}, wstrb 0001<<addr[1:0].
//   H: wdata {2{d[15:0]}}, wstrb 0011<<addr[1:0].
//   W: wdata d, wstrb 1111.
//  The unsigned bit is ignored for stores. Stores and faults: out_we=0, out_data=0.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles -> all outputs 0, in_ready=0; after release in_ready=1.
//  2 LW 0x100 (gnt in REQ, rvalid the next cycle, rdata 0xDEADBEEF) -> out_data 0xDEADBEEF, out_we=1, out_rd=rd_in.
//    out_valid 3 cycles after accept.
//  3 LB 0x103 with rdata 0x80123456 -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x102 with rdata 0x80011234 -> 0xFFFF8001.
//  4 SB 0x21, store_data 0x000000AB -> dmem_addr 0x20, wstrb 0010, wdata 0xABABABAB, we=1; out_we=0 on completion.
//  5 LW 0x102 -> no dmem_req, out_fault=1, cause 01, 1 cycle after accept; size=11 -> cause 11.
//  6 gnt never asserted -> dmem_req high for 64 cycles, then fault cause 10.
//    rst=0 during WAIT -> IDLE, and a later rvalid produces no out_valid.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Handshake bundle between EX, the load/store unit and data memory.
interface load_store_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_fault;
    logic [1:0]  out_cause;

    modport slave (
        input  in_valid, mem_op, addr, store_data, rd_in,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr,
        output dmem_wdata, dmem_wstrb,
        output out_valid, out_data, out_rd, out_we,
        output out_fault, out_cause
    );

    modport master (
        output in_valid, mem_op, addr, store_data, rd_in,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr,
        input  dmem_wdata, dmem_wstrb,
        input  out_valid, out_data, out_rd, out_we,
        input  out_fault, out_cause
    );
endinterface

// File: rtl/load_store_unit.sv
// Blocking memory stage: one data-memory read or write per accepted op,
// with alignment checks, load extension and a request timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE, S_REQ, S_WAIT, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_store;
    logic          r_uns;
    logic [1:0]    r_size;
    logic [1:0]    r_off;
    logic [4:0]    r_rd;
    logic [31:0]   r_daddr;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_data;
    logic          r_ld_we;
    logic          r_fault;
    logic [1:0]    r_cause;

    logic          w_accept;
    logic [1:0]    w_size;
    logic          w_illegal;
    logic          w_misal;
    logic          w_tmo;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_lane;
    logic [31:0]   w_ldata;

    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_size    = bus.mem_op[1:0];
    assign w_illegal = (w_size == 2'b11);
    assign w_misal   = ((w_size == 2'b01) & bus.addr[0])
                     | ((w_size == 2'b10) & (bus.addr[1:0] != 2'b00));
    assign w_tmo     = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)
                w_next = (w_illegal | w_misal) ? S_DONE : S_REQ;
            S_REQ: begin
                if (bus.dmem_gnt)
                    w_next = r_store ? S_DONE : S_WAIT;
                else if (w_tmo)
                    w_next = S_DONE;
            end
            S_WAIT: if (bus.dmem_rvalid | w_tmo)
                w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane replication lets memory pick any byte lane by strobe alone.
    always_comb begin
        w_wdata = bus.store_data;
        w_wstrb = 4'b1111;
        case (w_size)
            2'b00: begin
                w_wdata = {4{bus.store_data[7:0]}};
                w_wstrb = 4'b0001 << bus.addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{bus.store_data[15:0]}};
                w_wstrb = 4'b0011 << bus.addr[1:0];
            end
            default: ;
        endcase
    end

    assign w_lane = bus.dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ldata = w_lane;
        case (r_size)
            2'b00: w_ldata = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
            2'b01: w_ldata = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_store <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_rd    <= 5'd0;
            r_daddr <= 32'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'b0000;
            r_data  <= 32'd0;
            r_ld_we <= 1'b0;
            r_fault <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == S_REQ || r_state == S_WAIT)
                r_cnt <= r_cnt + CW'(1);
            if (w_accept) begin
                r_cnt   <= '0;
                r_store <= bus.mem_op[3];
                r_uns   <= bus.mem_op[2];
                r_size  <= w_size;
                r_off   <= bus.addr[1:0];
                r_rd    <= bus.rd_in;
                r_daddr <= {bus.addr[31:2], 2'b00};
                r_we    <= bus.mem_op[3];
                r_wdata <= bus.mem_op[3] ? w_wdata : 32'd0;
                r_wstrb <= bus.mem_op[3] ? w_wstrb : 4'b0000;
                r_data  <= 32'd0;
                r_ld_we <= 1'b0;
                r_fault <= w_illegal | w_misal;
                r_cause <= w_illegal ? 2'b11 :
                           (w_misal ? 2'b01 : 2'b00);
            end
            if (r_state == S_WAIT && bus.dmem_rvalid) begin
                r_data  <= w_ldata;
                r_ld_we <= 1'b1;
            end
            // gnt/rvalid take priority over an expiring counter.
            if ((r_state == S_REQ && !bus.dmem_gnt && w_tmo) ||
                (r_state == S_WAIT && !bus.dmem_rvalid && w_tmo)) begin
                r_fault <= 1'b1;
                r_cause <= 2'b10;
            end
        end
    end

    assign bus.in_ready   = rst & (r_state == S_IDLE);
    assign bus.dmem_req   = (r_state == S_REQ);
    assign bus.dmem_we    = (r_state == S_REQ) & r_we;
    assign bus.dmem_addr  = r_daddr;
    assign bus.dmem_wdata = r_wdata;
    assign bus.dmem_wstrb = r_wstrb;
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_data   = r_data;
    assign bus.out_rd     = r_rd;
    assign bus.out_we     = r_ld_we;
    assign bus.out_fault  = r_fault;
    assign bus.out_cause  = r_cause;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued
// when an op is issued and compared when out_valid fires.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
        logic        fault;
        logic [1:0]  cause;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        o_got;
    int          o_lat;
    int          o_req;
    logic [31:0] o_data;
    logic        o_we;
    logic [4:0]  o_rd;
    logic        o_fault;
    logic [1:0]  o_cause;
    logic [31:0] o_maddr;
    logic [31:0] o_mwdata;
    logic [3:0]  o_mwstrb;
    logic        o_mwe;

    // Issues one op and plays the memory side; records what it observed.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rd,
                          input logic [31:0] word, input bit give_gnt,
                          input int gnt_delay);
        bit pend_r;
        pend_r = 0;
        o_got = 0; o_lat = 0; o_req = 0;
        o_maddr = '0; o_mwdata = '0; o_mwstrb = '0; o_mwe = 0;
        for (int i = 0; i < 10 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1; bus.mem_op = op; bus.addr = a;
        bus.store_data = sd; bus.rd_in = rd;
        @(posedge clk); #1;
        bus.in_valid = 0;
        o_lat = 1;
        for (int c = 0; c < 200 && !o_got; c++) begin
            if (bus.out_valid) begin
                o_got = 1; o_data = bus.out_data; o_we = bus.out_we;
                o_rd = bus.out_rd; o_fault = bus.out_fault;
                o_cause = bus.out_cause;
            end else begin
                if (bus.dmem_req) begin
                    o_req++;
                    o_maddr = bus.dmem_addr; o_mwdata = bus.dmem_wdata;
                    o_mwstrb = bus.dmem_wstrb; o_mwe = bus.dmem_we;
                    if (give_gnt && o_req > gnt_delay) begin
                        bus.dmem_gnt = 1;
                        pend_r = !op[3];
                    end
                end else if (pend_r) begin
                    bus.dmem_rvalid = 1; bus.dmem_rdata = word;
                    pend_r = 0;
                end
                @(posedge clk); #1;
                bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
                o_lat++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
        end
        n_cmp++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata,
             bus.dmem_wstrb} !== 70'd0) begin
            n_bad++; $display("FAIL rst_dmem got nonzero want 0");
        end
        n_cmp++;
        if ({bus.out_valid, bus.out_data, bus.out_rd, bus.out_we,
             bus.out_fault, bus.out_cause} !== 42'd0) begin
            n_bad++; $display("FAIL rst_out got nonzero want 0");
        end
        rst = 1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_release got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_loads();
        logic [3:0]  ops[4]   = '{4'b0010, 4'b0000, 4'b0100, 4'b0001};
        logic [31:0] adrs[4]  = '{32'h100, 32'h103, 32'h103, 32'h102};
        logic [31:0] words[4] = '{32'hDEADBEEF, 32'h80123456,
                                  32'h80123456, 32'h80011234};
        logic [31:0] res[4]   = '{32'hDEADBEEF, 32'hFFFFFF80,
                                  32'h00000080, 32'hFFFF8001};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{res[i], 1'b1, 5'(i + 3), 1'b0, 2'b00, 3});
            run_op(ops[i], adrs[i], 32'h0, 5'(i + 3), words[i], 1, 0);
            e = sb.pop_front();
            n_cmp++;
            if (o_got !== 1'b1) begin
                n_bad++; $display("FAIL ld%0d_done got %b want 1", i, o_got);
            end
            n_cmp++;
            if (o_data !== e.data) begin
                n_bad++;
                $display("FAIL ld%0d_data got %h want %h", i, o_data, e.data);
            end
            n_cmp++;
            if ({o_we, o_rd, o_fault} !== {e.we, e.rd, e.fault}) begin
                n_bad++;
                $display("FAIL ld%0d_ctl got %b/%0d/%b want %b/%0d/%b",
                         i, o_we, o_rd, o_fault, e.we, e.rd, e.fault);
            end
            n_cmp++;
            if (o_lat != e.lat) begin
                n_bad++; $display("FAIL ld%0d_lat got %0d want %0d", i, o_lat, e.lat);
            end
            n_cmp++;
            if ({o_maddr, o_mwstrb, o_mwe} !== {adrs[i] & ~32'h3, 4'b0000, 1'b0}) begin
                n_bad++;
                $display("FAIL ld%0d_bus got %h/%b/%b want %h/0000/0",
                         i, o_maddr, o_mwstrb, o_mwe, adrs[i] & ~32'h3);
            end
        end
    endtask

    task automatic test_store();
        exp_t e;
        sb.push_back('{32'h0, 1'b0, 5'd9, 1'b0, 2'b00, 2});
        run_op(4'b1000, 32'h21, 32'h000000AB, 5'd9, 32'h0, 1, 0);
        e = sb.pop_front();
        n_cmp++;
        if ({o_maddr, o_mwstrb, o_mwdata, o_mwe} !==
            {32'h20, 4'b0010, 32'hABABABAB, 1'b1}) begin
            n_bad++;
            $display("FAIL sb_bus got %h/%b/%h/%b want 20/0010/abababab/1",
                     o_maddr, o_mwstrb, o_mwdata, o_mwe);
        end
        n_cmp++;
        if ({o_got, o_we, o_data, o_fault} !== {1'b1, e.we, e.data, e.fault}) begin
            n_bad++; $display("FAIL sb_out got %b/%b/%h want 1/0/0", o_got, o_we, o_data);
        end
        n_cmp++;
        if (o_lat != e.lat) begin
            n_bad++; $display("FAIL sb_lat got %0d want %0d", o_lat, e.lat);
        end
        // Halfword store at offset 2 with unsigned bit set (ignored).
        run_op(4'b1101, 32'h46, 32'h1234CDEF, 5'd2, 32'h0, 1, 0);
        n_cmp++;
        if ({o_maddr, o_mwstrb, o_mwdata} !== {32'h44, 4'b1100, 32'hCDEFCDEF}) begin
            n_bad++;
            $display("FAIL sh_bus got %h/%b/%h want 44/1100/cdefcdef",
                     o_maddr, o_mwstrb, o_mwdata);
        end
    endtask

    task automatic test_faults();
        exp_t e;
        sb.push_back('{32'h0, 1'b0, 5'd4, 1'b1, 2'b01, 1});
        run_op(4'b0010, 32'h102, 32'h0, 5'd4, 32'h0, 1, 0);
        e = sb.pop_front();
        n_cmp++;
        if ({o_got, o_fault, o_cause, o_we, o_data} !==
            {1'b1, e.fault, e.cause, e.we, e.data}) begin
            n_bad++; $display("FAIL misal got %b/%b/%b want 1/1/01", o_got, o_fault, o_cause);
        end
        n_cmp++;
        if (o_lat != e.lat || o_req != 0) begin
            n_bad++; $display("FAIL misal_lat got %0d/req%0d want 1/req0", o_lat, o_req);
        end
        sb.push_back('{32'h0, 1'b0, 5'd5, 1'b1, 2'b11, 1});
        run_op(4'b1011, 32'h100, 32'h0, 5'd5, 32'h0, 1, 0);
        e = sb.pop_front();
        n_cmp++;
        if ({o_got, o_fault, o_cause, o_req == 0} !== {1'b1, e.fault, e.cause, 1'b1}) begin
            n_bad++; $display("FAIL illegal got %b/%b/%b want 1/1/11", o_got, o_fault, o_cause);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        sb.push_back('{32'h0, 1'b0, 5'd7, 1'b1, 2'b10, 65});
        run_op(4'b0010, 32'h200, 32'h0, 5'd7, 32'h0, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (o_req != 64) begin
            n_bad++; $display("FAIL tmo_req got %0d want 64", o_req);
        end
        n_cmp++;
        if ({o_got, o_fault, o_cause, o_we} !== {1'b1, e.fault, e.cause, e.we}) begin
            n_bad++; $display("FAIL tmo_out got %b/%b/%b want 1/1/10", o_got, o_fault, o_cause);
        end
        n_cmp++;
        if (o_lat != e.lat) begin
            n_bad++; $display("FAIL tmo_lat got %0d want %0d", o_lat, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{32'h0, 1'b0, 5'd1, 1'b0, 2'b00, 4});
        sb.push_back('{32'h55AA00FF, 1'b1, 5'd31, 1'b0, 2'b00, 3});
        run_op(4'b1010, 32'h300, 32'h11223344, 5'd1, 32'h0, 1, 2);
        e = sb.pop_front();
        n_cmp++;
        if (o_lat != e.lat || o_mwdata !== 32'h11223344 || o_mwstrb !== 4'b1111) begin
            n_bad++;
            $display("FAIL sw_wait got %0d/%h/%b want %0d/11223344/1111",
                     o_lat, o_mwdata, o_mwstrb, e.lat);
        end
        run_op(4'b0010, 32'h304, 32'h0, 5'd31, 32'h55AA00FF, 1, 0);
        e = sb.pop_front();
        n_cmp++;
        if ({o_data, o_rd, o_we} !== {e.data, e.rd, e.we} || o_lat != e.lat) begin
            n_bad++; $display("FAIL b2b_lw got %h/%0d lat%0d want %h/%0d", o_data,
                              o_rd, o_lat, e.data, e.rd);
        end
    endtask

    task automatic test_reset_mid_op();
        int spurious;
        spurious = 0;
        bus.in_valid = 1; bus.mem_op = 4'b0010; bus.addr = 32'h40;
        bus.rd_in = 5'd6;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.dmem_gnt = 1;
        @(posedge clk); #1;
        bus.dmem_gnt = 0;
        rst = 0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.dmem_req, bus.in_ready, bus.out_valid} !== 3'b000) begin
            n_bad++; $display("FAIL midrst_state got %b want 000",
                              {bus.dmem_req, bus.in_ready, bus.out_valid});
        end
        rst = 1;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) spurious++;
        end
        bus.dmem_rvalid = 0;
        n_cmp++;
        if (spurious != 0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_late got %0d pulses rdy %b want 0 rdy 1",
                              spurious, bus.in_ready);
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.mem_op = '0; bus.addr = '0;
        bus.store_data = '0; bus.rd_in = '0;
        bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
        test_reset();
        test_loads();
        test_store();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
